// File: rtl/sap1_pkg.sv
// SAP-1 shared definitions: opcodes, control-word bit positions, T-state indices
// and the ring-counter decode. Optional macro: SAP1_ONEHOT_CHECK_EN.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CON_CP = 11;
    localparam int CON_EP = 10;
    localparam int CON_LM = 9;
    localparam int CON_CE = 8;
    localparam int CON_LI = 7;
    localparam int CON_EI = 6;
    localparam int CON_LA = 5;
    localparam int CON_EA = 4;
    localparam int CON_SU = 3;
    localparam int CON_EU = 2;
    localparam int CON_LB = 1;
    localparam int CON_LO = 0;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    typedef enum logic [2:0] {
        TS_NONE = 3'd0,
        TS_T1   = 3'd1,
        TS_T2   = 3'd2,
        TS_T3   = 3'd3,
        TS_T4   = 3'd4,
        TS_T5   = 3'd5,
        TS_T6   = 3'd6
    } tstate_e;

    // Lowest set bit wins; with the check enabled, anything not one-hot is TS_NONE.
    function automatic tstate_e decode_state(input logic [5:0] s);
        tstate_e t;
        if (s[T1])      t = TS_T1;
        else if (s[T2]) t = TS_T2;
        else if (s[T3]) t = TS_T3;
        else if (s[T4]) t = TS_T4;
        else if (s[T5]) t = TS_T5;
        else if (s[T6]) t = TS_T6;
        else            t = TS_NONE;
`ifdef SAP1_ONEHOT_CHECK_EN
        if ((s & (s - 6'd1)) != 6'd0) t = TS_NONE;
`endif
        return t;
    endfunction

endpackage

// File: rtl/sap1_con_seq.sv
// SAP-1 controller-sequencer: purely combinational (op_code, state, halted) -> con.
// Optional macro: SAP1_ONEHOT_CHECK_EN (via sap1_pkg::decode_state).
module sap1_con_seq
    import sap1_pkg::*;
(
    input  logic [3:0]  op_code,
    input  logic [5:0]  state,
    input  logic        halted,
    output logic [11:0] con
);

    always_comb begin
        con = '0;
        if (!halted) begin
            case (decode_state(state))
                TS_T1: begin
                    con[CON_EP] = 1'b1;
                    con[CON_LM] = 1'b1;
                end
                TS_T2: con[CON_CP] = 1'b1;
                TS_T3: begin
                    con[CON_CE] = 1'b1;
                    con[CON_LI] = 1'b1;
                end
                TS_T4: begin
                    case (op_code)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            con[CON_EI] = 1'b1;
                            con[CON_LM] = 1'b1;
                        end
                        OP_OUT: begin
                            con[CON_EA] = 1'b1;
                            con[CON_LO] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                TS_T5: begin
                    case (op_code)
                        OP_LDA: begin
                            con[CON_CE] = 1'b1;
                            con[CON_LA] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            con[CON_CE] = 1'b1;
                            con[CON_LB] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                TS_T6: begin
                    case (op_code)
                        OP_ADD: begin
                            con[CON_LA] = 1'b1;
                            con[CON_EU] = 1'b1;
                        end
                        OP_SUB: begin
                            con[CON_LA] = 1'b1;
                            con[CON_SU] = 1'b1;
                            con[CON_EU] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sap1_ctrl_core.sv
// SAP-1 control core: accumulator, instruction register, sticky halt flag and decoder.
// Optional macro: SAP1_ONEHOT_CHECK_EN (non-one-hot state forces con to zero).
module sap1_ctrl_core
    import sap1_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [5:0]  state,
    input  logic [7:0]  bus_in,
    output logic [11:0] con,
    output logic [7:0]  acc_bus,
    output logic        acc_bus_oe,
    output logic [7:0]  acc_alu,
    output logic [3:0]  ir_addr,
    output logic        ir_addr_oe,
    output logic [3:0]  op_code,
    output logic        halted
);

    logic [7:0] acc;
    logic [7:0] ir;
    logic       halt_hit;

    sap1_con_seq u_con_seq (
        .op_code (op_code),
        .state   (state),
        .halted  (halted),
        .con     (con)
    );

    // HLT is recognised at T4 even though its T4 control word is empty.
    assign halt_hit = (decode_state(state) == TS_T4) && (op_code == OP_HLT);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc    <= 8'h00;
            ir     <= 8'h00;
            halted <= 1'b0;
        end else begin
            if (con[CON_LI]) ir <= bus_in;
            if (con[CON_LA]) acc <= bus_in;
            if (halt_hit) halted <= 1'b1;
        end
    end

    assign op_code    = ir[7:4];
    assign acc_alu    = acc;
    assign acc_bus_oe = con[CON_EA];
    assign acc_bus    = con[CON_EA] ? acc : 8'h00;
    assign ir_addr_oe = con[CON_EI];
    assign ir_addr    = con[CON_EI] ? ir[3:0] : 4'h0;

endmodule

// File: tb/tb_sap1_ctrl_core.sv
// Bench for sap1_ctrl_core: directed scenarios plus randomized instruction streams
// checked against a table-driven microcode model of the SAP-1 controller.
module tb_sap1_ctrl_core;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [5:0]  state = 6'd0;
    logic [7:0]  bus_in = 8'h00;
    logic [11:0] con;
    logic [7:0]  acc_bus;
    logic        acc_bus_oe;
    logic [7:0]  acc_alu;
    logic [3:0]  ir_addr;
    logic        ir_addr_oe;
    logic [3:0]  op_code;
    logic        halted;

    sap1_ctrl_core dut (
        .clk        (clk),
        .clr        (clr),
        .state      (state),
        .bus_in     (bus_in),
        .con        (con),
        .acc_bus    (acc_bus),
        .acc_bus_oe (acc_bus_oe),
        .acc_alu    (acc_alu),
        .ir_addr    (ir_addr),
        .ir_addr_oe (ir_addr_oe),
        .op_code    (op_code),
        .halted     (halted)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [11:0] ucode [0:5][0:5];
    logic [7:0]  m_acc = 8'h00;
    logic [7:0]  m_ir  = 8'h00;
    logic        m_halt = 1'b0;
    logic [11:0] exp_q [$];

    function automatic int model_t(input logic [5:0] st);
        int t;
        t = -1;
        for (int i = 0; i < 6; i++)
            if (st[i] && t < 0) t = i;
`ifdef SAP1_ONEHOT_CHECK_EN
        if ($countones(st) != 1) t = -1;
`endif
        return t;
    endfunction

    function automatic int op_class(input logic [3:0] op);
        case (op)
            4'h0:    return 0;
            4'h1:    return 1;
            4'h2:    return 2;
            4'hE:    return 3;
            4'hF:    return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [11:0] model_con(input logic [5:0] st, input logic [3:0] op,
                                              input logic h);
        int t;
        t = model_t(st);
        if (h || t < 0) return 12'h000;
        return ucode[op_class(op)][t];
    endfunction

    // driver tasks
    task automatic drive(input logic [5:0] st, input logic [7:0] b);
        state  = st;
        bus_in = b;
        #1;
    endtask

    task automatic tick();
        logic [11:0] c;
        logic        ht;
        logic [7:0]  b;
        c  = model_con(state, m_ir[7:4], m_halt);
        ht = (model_t(state) == 3) && (m_ir[7:4] == 4'hF);
        b  = bus_in;
        @(posedge clk);
        if (c[7]) m_ir = b;
        if (c[5]) m_acc = b;
        if (ht) m_halt = 1'b1;
        #1;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        #2;
        clr = 1'b0;
        m_acc  = 8'h00;
        m_ir   = 8'h00;
        m_halt = 1'b0;
        #1;
    endtask

    task automatic fetch(input logic [7:0] instr);
        drive(6'b000001, 8'($urandom)); tick();
        drive(6'b000010, 8'($urandom)); tick();
        drive(6'b000100, instr);        tick();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        drive(6'b000001, 8'hFF);
        #2;
        n_checks++; if (acc_alu !== 8'h00) begin n_fail++; $display("FAIL reset_acc got %h exp 00", acc_alu); end
        n_checks++; if (op_code !== 4'h0) begin n_fail++; $display("FAIL reset_op got %h exp 0", op_code); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
        n_checks++; if (con !== 12'h600) begin n_fail++; $display("FAIL reset_con got %h exp 600", con); end
        @(negedge clk);
        clr = 1'b0;
        m_acc = 8'h00; m_ir = 8'h00; m_halt = 1'b0;
        tick();
    endtask

    task automatic test_fetch_add();
        drive(6'b000001, 8'h33);
        n_checks++; if (con !== 12'h600) begin n_fail++; $display("FAIL fetch_t1 got %h exp 600", con); end
        tick();
        drive(6'b000010, 8'h44);
        n_checks++; if (con !== 12'h800) begin n_fail++; $display("FAIL fetch_t2 got %h exp 800", con); end
        tick();
        drive(6'b000100, 8'h1A);
        n_checks++; if (con !== 12'h180) begin n_fail++; $display("FAIL fetch_t3 got %h exp 180", con); end
        tick();
        n_checks++; if (op_code !== 4'h1) begin n_fail++; $display("FAIL fetch_op got %h exp 1", op_code); end
        drive(6'b001000, 8'h00);
        n_checks++; if (con !== 12'h240) begin n_fail++; $display("FAIL add_t4 got %h exp 240", con); end
        n_checks++; if (ir_addr !== 4'hA || ir_addr_oe !== 1'b1)
            begin n_fail++; $display("FAIL add_iraddr got %h/%b exp a/1", ir_addr, ir_addr_oe); end
        tick();
        drive(6'b010000, 8'h09);
        n_checks++; if (con !== 12'h102) begin n_fail++; $display("FAIL add_t5 got %h exp 102", con); end
        n_checks++; if (ir_addr !== 4'h0 || ir_addr_oe !== 1'b0)
            begin n_fail++; $display("FAIL add_iraddr_off got %h/%b exp 0/0", ir_addr, ir_addr_oe); end
        tick();
        drive(6'b100000, 8'h05);
        n_checks++; if (con !== 12'h024) begin n_fail++; $display("FAIL add_t6 got %h exp 024", con); end
        tick();
        n_checks++; if (acc_alu !== 8'h05) begin n_fail++; $display("FAIL add_acc got %h exp 05", acc_alu); end
    endtask

    task automatic test_lda();
        fetch(8'h0B);
        drive(6'b001000, 8'h77);
        n_checks++; if (con !== 12'h240) begin n_fail++; $display("FAIL lda_t4 got %h exp 240", con); end
        tick();
        drive(6'b010000, 8'h2C);
        n_checks++; if (con !== 12'h120) begin n_fail++; $display("FAIL lda_t5 got %h exp 120", con); end
        tick();
        n_checks++; if (acc_alu !== 8'h2C) begin n_fail++; $display("FAIL lda_acc got %h exp 2c", acc_alu); end
        drive(6'b100000, 8'h99);
        n_checks++; if (con !== 12'h000) begin n_fail++; $display("FAIL lda_t6 got %h exp 000", con); end
        tick();
        n_checks++; if (acc_alu !== 8'h2C) begin n_fail++; $display("FAIL lda_hold got %h exp 2c", acc_alu); end
    endtask

    task automatic test_sub_out();
        fetch(8'h2C);
        drive(6'b001000, 8'h00); tick();
        drive(6'b010000, 8'h07);
        n_checks++; if (con !== 12'h102) begin n_fail++; $display("FAIL sub_t5 got %h exp 102", con); end
        tick();
        drive(6'b100000, 8'h0E);
        n_checks++; if (con !== 12'h02C) begin n_fail++; $display("FAIL sub_t6 got %h exp 02c", con); end
        tick();
        n_checks++; if (acc_alu !== 8'h0E) begin n_fail++; $display("FAIL sub_acc got %h exp 0e", acc_alu); end
        fetch(8'hE0);
        drive(6'b001000, 8'h55);
        n_checks++; if (con !== 12'h011) begin n_fail++; $display("FAIL out_t4 got %h exp 011", con); end
        n_checks++; if (acc_bus !== 8'h0E || acc_bus_oe !== 1'b1)
            begin n_fail++; $display("FAIL out_accbus got %h/%b exp 0e/1", acc_bus, acc_bus_oe); end
        tick();
        drive(6'b010000, 8'h55);
        n_checks++; if (con !== 12'h000 || acc_bus !== 8'h00)
            begin n_fail++; $display("FAIL out_t5 got %h/%h exp 000/00", con, acc_bus); end
        tick();
    endtask

    task automatic test_hlt();
        logic [7:0] acc_before;
        acc_before = m_acc;
        fetch(8'hF0);
        drive(6'b001000, 8'h3C);
        n_checks++; if (con !== 12'h000) begin n_fail++; $display("FAIL hlt_t4 got %h exp 000", con); end
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hlt_set got %b exp 1", halted); end
        for (int i = 0; i < 6; i++) begin
            drive(6'(1 << i), 8'($urandom));
            n_checks++; if (con !== 12'h000) begin n_fail++; $display("FAIL hlt_con t%0d got %h exp 000", i + 1, con); end
            tick();
        end
        n_checks++; if (acc_alu !== acc_before) begin n_fail++; $display("FAIL hlt_acc got %h exp %h", acc_alu, acc_before); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hlt_sticky got %b exp 1", halted); end
        clr_pulse();
        n_checks++; if (halted !== 1'b0 || acc_alu !== 8'h00 || op_code !== 4'h0)
            begin n_fail++; $display("FAIL hlt_clr got %b/%h/%h exp 0/00/0", halted, acc_alu, op_code); end
    endtask

    task automatic test_state_check();
        logic [11:0] e_multi;
        logic [11:0] e_t3;
`ifdef SAP1_ONEHOT_CHECK_EN
        e_multi = 12'h000;
        e_t3    = 12'h000;
`else
        e_multi = 12'h600;
        e_t3    = 12'h180;
`endif
        drive(6'b000101, 8'h00);
        n_checks++; if (con !== e_multi) begin n_fail++; $display("FAIL state_multi got %h exp %h", con, e_multi); end
        tick();
        drive(6'b000000, 8'h00);
        n_checks++; if (con !== 12'h000) begin n_fail++; $display("FAIL state_zero got %h exp 000", con); end
        tick();
        drive(6'b001100, 8'h00);
        n_checks++; if (con !== e_t3) begin n_fail++; $display("FAIL state_t3t4 got %h exp %h", con, e_t3); end
        tick();
    endtask

    task automatic test_random();
        int          tpos;
        logic [5:0]  st;
        logic [7:0]  b;
        logic [3:0]  op;
        logic [11:0] ec;
        tpos = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) st = 6'($urandom_range(0, 63));
            else st = 6'(1 << tpos);
            b = 8'($urandom);
            if (tpos == 2) begin
                case ($urandom_range(0, 11))
                    0, 1:    op = 4'h0;
                    2, 3, 4: op = 4'h1;
                    5, 6, 7: op = 4'h2;
                    8:       op = 4'hE;
                    9:       op = 4'hF;
                    default: op = 4'($urandom);
                endcase
                b = {op, b[3:0]};
            end
            drive(st, b);
            exp_q.push_back(model_con(st, m_ir[7:4], m_halt));
            ec = exp_q.pop_front();
            n_checks++; if (con !== ec) begin n_fail++; $display("FAIL rnd_con n=%0d st=%b got %h exp %h", n, st, con, ec); end
            n_checks++; if (acc_alu !== m_acc) begin n_fail++; $display("FAIL rnd_acc n=%0d got %h exp %h", n, acc_alu, m_acc); end
            n_checks++; if (op_code !== m_ir[7:4] || halted !== m_halt)
                begin n_fail++; $display("FAIL rnd_op_halt n=%0d got %h/%b exp %h/%b", n, op_code, halted, m_ir[7:4], m_halt); end
            n_checks++; if (acc_bus !== (ec[4] ? m_acc : 8'h00) || acc_bus_oe !== ec[4])
                begin n_fail++; $display("FAIL rnd_accbus n=%0d got %h/%b", n, acc_bus, acc_bus_oe); end
            n_checks++; if (ir_addr !== (ec[6] ? m_ir[3:0] : 4'h0) || ir_addr_oe !== ec[6])
                begin n_fail++; $display("FAIL rnd_iraddr n=%0d got %h/%b", n, ir_addr, ir_addr_oe); end
            tick();
            tpos = (tpos + 1) % 6;
            if (m_halt && $urandom_range(0, 3) == 0) begin
                clr_pulse();
                n_checks++; if (halted !== 1'b0 || acc_alu !== 8'h00)
                    begin n_fail++; $display("FAIL rnd_clr n=%0d got %b/%h exp 0/00", n, halted, acc_alu); end
                tpos = 0;
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 6; c++) begin
            ucode[c][0] = 12'h600;
            ucode[c][1] = 12'h800;
            ucode[c][2] = 12'h180;
            ucode[c][3] = 12'h000;
            ucode[c][4] = 12'h000;
            ucode[c][5] = 12'h000;
        end
        ucode[0][3] = 12'h240; ucode[0][4] = 12'h120;
        ucode[1][3] = 12'h240; ucode[1][4] = 12'h102; ucode[1][5] = 12'h024;
        ucode[2][3] = 12'h240; ucode[2][4] = 12'h102; ucode[2][5] = 12'h02C;
        ucode[3][3] = 12'h011;

        test_reset();
        test_fetch_add();
        test_lda();
        test_sub_out();
        test_hlt();
        test_state_check();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
